// File: rtl/scoreboard.sv
// Register/CSR hazard scoreboard for an in-order pipeline.
// Each architectural register x1..x31 has a 2-bit count of writes that have
// been issued but not yet retired. Decode stalls on read-after-write, on a
// fourth outstanding write to one register, and (optionally) on CSR hazards.
// Optional feature macro: SCOREBOARD_CSR_EN adds a 2-bit CSR pending counter.
module scoreboard (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_ren_i,
  input  logic       id_rs2_ren_i,
  input  logic [4:0] id_rd_i,
  input  logic       id_wen_i,
  input  logic       id_csr_ren_i,
  input  logic       id_csr_wen_i,
  input  logic       ex_ready_i,
  input  logic       wb_valid_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_wen_i,
  input  logic       wb_csr_wen_i,
  input  logic       flush_i,
  output logic       stall_o,
  output logic       issue_o,
  output logic       busy_o,
  output logic [2:0] inflight_o,
  output logic       err_o
);

  localparam int NREG = 32;

  // Entry 0 is held at zero so x0 never reports a pending write.
  logic [1:0] cnt_q [NREG];
  logic [1:0] cnt_d [NREG];
  logic       err_q, err_d;

  logic       raw_hazard, waw_full, csr_hazard;
  logic       inc_en, dec_en;
  logic       reg_uf, csr_uf, csr_busy;
  logic [6:0] cnt_sum;

  // Hazards look only at registered counts: a retire this cycle does not
  // release a dependent instruction until the following cycle.
  assign raw_hazard = (id_rs1_ren_i && (cnt_q[id_rs1_i] != 2'd0)) ||
                      (id_rs2_ren_i && (cnt_q[id_rs2_i] != 2'd0));
  assign waw_full   = id_wen_i && (id_rd_i != 5'd0) && (cnt_q[id_rd_i] == 2'd3);

  assign stall_o = id_valid_i && (raw_hazard || waw_full || csr_hazard);
  assign issue_o = id_valid_i && !stall_o && ex_ready_i && !flush_i;

  assign inc_en = issue_o && id_wen_i && (id_rd_i != 5'd0);
  assign dec_en = wb_valid_i && wb_wen_i && (wb_rd_i != 5'd0);

  // Next count per register: flush clears, same-register inc+dec cancel,
  // and a decrement of an empty counter is flagged instead of wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    reg_uf = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0 || flush_i) begin
        cnt_d[r] = 2'd0;
      end else begin
        case ({inc_en && (id_rd_i == 5'(r)), dec_en && (wb_rd_i == 5'(r))})
          2'b10:   cnt_d[r] = cnt_q[r] + 2'd1;
          2'b01: begin
            if (cnt_q[r] == 2'd0) reg_uf = 1'b1;
            else                  cnt_d[r] = cnt_q[r] - 2'd1;
          end
          default: cnt_d[r] = cnt_q[r];
        endcase
      end
    end
  end

  // Total outstanding register writes, saturated to the 3-bit output.
  always_comb begin
    cnt_sum = 7'd0;
    for (int r = 0; r < NREG; r++) begin
      cnt_sum = cnt_sum + 7'(cnt_q[r]);
    end
    inflight_o = (cnt_sum > 7'd7) ? 3'd7 : cnt_sum[2:0];
  end

`ifdef SCOREBOARD_CSR_EN
  logic [1:0] csr_cnt_q, csr_cnt_d;
  logic       csr_inc, csr_dec;

  assign csr_inc    = issue_o && id_csr_wen_i;
  assign csr_dec    = wb_valid_i && wb_csr_wen_i;
  assign csr_hazard = (id_csr_ren_i || id_csr_wen_i) && (csr_cnt_q != 2'd0);
  assign csr_busy   = (csr_cnt_q != 2'd0);

  // CSR pending count follows the same inc/dec/underflow rules as registers.
  always_comb begin
    csr_cnt_d = csr_cnt_q;
    csr_uf    = 1'b0;
    if (flush_i) begin
      csr_cnt_d = 2'd0;
    end else begin
      case ({csr_inc, csr_dec})
        2'b10:   csr_cnt_d = csr_cnt_q + 2'd1;
        2'b01: begin
          if (csr_cnt_q == 2'd0) csr_uf = 1'b1;
          else                   csr_cnt_d = csr_cnt_q - 2'd1;
        end
        default: csr_cnt_d = csr_cnt_q;
      endcase
    end
  end

  // CSR counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) csr_cnt_q <= 2'd0;
    else          csr_cnt_q <= csr_cnt_d;
  end
`else
  logic unused_csr;

  assign csr_hazard = 1'b0;
  assign csr_busy   = 1'b0;
  assign csr_uf     = 1'b0;
  assign unused_csr = ^{id_csr_ren_i, id_csr_wen_i, wb_csr_wen_i};
`endif

  // Sticky underflow flag; flush does not clear it, only reset does.
  always_comb begin
    err_d = err_q || reg_uf || csr_uf;
  end

  // Counter and error state; reset discards everything asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order. The counter array is
    // reset element by element because it is live pipeline state held in
    // flops, not a RAM, and stale counts would stall forever.
    if (!rst_n_i) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= 2'd0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  assign err_o  = err_q;
  assign busy_o = (inflight_o != 3'd0) || csr_busy;

endmodule

// File: tb/tb_scoreboard.sv
// Directed, table-driven bench for the scoreboard, plus hand-written
// sequences for flush, CSR hazards and asynchronous reset.
module tb_scoreboard;

  logic       clk, rst_n;
  logic       id_valid, id_rs1_ren, id_rs2_ren, id_wen, id_csr_ren, id_csr_wen;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic       ex_ready, wb_valid, wb_wen, wb_csr_wen, flush;
  logic       stall, issue, busy, err;
  logic [2:0] inflight;

  int errors = 0;
  int checks = 0;

  scoreboard dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .id_valid_i   (id_valid),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_rs1_ren_i (id_rs1_ren),
    .id_rs2_ren_i (id_rs2_ren),
    .id_rd_i      (id_rd),
    .id_wen_i     (id_wen),
    .id_csr_ren_i (id_csr_ren),
    .id_csr_wen_i (id_csr_wen),
    .ex_ready_i   (ex_ready),
    .wb_valid_i   (wb_valid),
    .wb_rd_i      (wb_rd),
    .wb_wen_i     (wb_wen),
    .wb_csr_wen_i (wb_csr_wen),
    .flush_i      (flush),
    .stall_o      (stall),
    .issue_o      (issue),
    .busy_o       (busy),
    .inflight_o   (inflight),
    .err_o        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       r1;
    logic [4:0] rs2;
    logic       r2;
    logic [4:0] rd;
    logic       wen;
    logic       rdy;
    logic       wb;
    logic [4:0] wbrd;
    logic       e_stall;
    logic       e_issue;
    logic [2:0] e_infl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic r1,
                              input logic [4:0] rs2, input logic r2,
                              input logic [4:0] rd, input logic wen, input logic rdy,
                              input logic wb, input logic [4:0] wbrd,
                              input logic e_stall, input logic e_issue,
                              input logic [2:0] e_infl);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.r1 = r1; t.rs2 = rs2; t.r2 = r2;
    t.rd = rd; t.wen = wen; t.rdy = rdy; t.wb = wb; t.wbrd = wbrd;
    t.e_stall = e_stall; t.e_issue = e_issue; t.e_infl = e_infl;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_ren = 0; id_rs2_ren = 0;
    id_rd = 0; id_wen = 0; id_csr_ren = 0; id_csr_wen = 0; ex_ready = 1;
    wb_valid = 0; wb_rd = 0; wb_wen = 0; wb_csr_wen = 0; flush = 0;
  endtask

  task automatic apply(input vec_t t);
    idle();
    id_valid = t.v; id_rs1 = t.rs1; id_rs1_ren = t.r1; id_rs2 = t.rs2; id_rs2_ren = t.r2;
    id_rd = t.rd; id_wen = t.wen; ex_ready = t.rdy;
    wb_valid = t.wb; wb_wen = t.wb; wb_rd = t.wbrd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_write(input logic [4:0] rd);
    idle();
    id_valid = 1; id_rd = rd; id_wen = 1;
    @(negedge clk);
    check($sformatf("issue_w%0d", rd), issue, 1);
    tick();
  endtask

  initial begin
    // Vector table: each entry is one cycle, checked before the edge.
    // RAW on x5 released only the cycle after the retire edge.
    vecs.push_back(mk(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 5, 1, 1, 1, 6, 1, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 5, 1, 1, 1, 6, 1, 1, 1, 5, 1, 0, 1));
    vecs.push_back(mk(1, 5, 1, 1, 1, 6, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0, 0, 1));
    // Three writes to x7 fill its counter; the fourth waits for a retire.
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 1, 7, 1, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 2));
    // Same-cycle issue and retire of x7 leaves its count at 1.
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 1, 7, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // x0 is never tracked.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0));
    // Execute not ready: no stall, but no issue either.
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0));
    // Eight outstanding writes: inflight saturates at 7.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 5'(10 + i), 1, 1, 0, 0, 0, 1, 3'(i)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 5'(10 + i), 0, 0,
                        (8 - i > 7) ? 3'd7 : 3'(8 - i)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // RAW through rs2, and read-enables gate the hazard.
    vecs.push_back(mk(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 3, 1, 12, 1, 13, 1, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 12, 0, 12, 0, 13, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 12, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 13, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    // Reset state.
    idle();
    rst_n = 0;
    #2;
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    check("rst_inflight", inflight, 0);
    check("rst_err", err, 0);
    #10 rst_n = 1;
    tick();

    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
      check($sformatf("v%0d_issue", i), issue, vecs[i].e_issue);
      check($sformatf("v%0d_inflight", i), inflight, vecs[i].e_infl);
      check($sformatf("v%0d_busy", i), busy, vecs[i].e_infl != 0);
      check($sformatf("v%0d_err", i), err, 0);
      tick();
    end

    // Flush beats same-cycle issue and retire, and clears pending x3.
    issue_write(5'd3);
    idle();
    id_valid = 1; id_rd = 9; id_wen = 1;
    wb_valid = 1; wb_rd = 3; wb_wen = 1; flush = 1;
    @(negedge clk);
    check("flush_issue", issue, 0);
    check("flush_inflight_before", inflight, 1);
    tick();
    idle();
    @(negedge clk);
    check("flush_inflight_after", inflight, 0);
    check("flush_busy_after", busy, 0);
    check("flush_err_after", err, 0);
    tick();
    wb_valid = 1; wb_rd = 3; wb_wen = 1;
    @(negedge clk);
    check("uf_err_before", err, 0);
    tick();
    idle();
    @(negedge clk);
    check("uf_err_set", err, 1);
    tick();
    @(negedge clk);
    check("uf_err_sticky", err, 1);
    tick();

    // CSR hazard: csrrw then csrrs.
    idle();
    id_valid = 1; id_csr_ren = 1; id_csr_wen = 1;
    @(negedge clk);
    check("csr1_issue", issue, 1);
    tick();
    @(negedge clk);
`ifdef SCOREBOARD_CSR_EN
    check("csr2_stall", stall, 1);
    check("csr2_issue", issue, 0);
    check("csr2_busy", busy, 1);
`else
    check("csr2_stall", stall, 0);
    check("csr2_issue", issue, 1);
    check("csr2_busy", busy, 0);
`endif
    check("csr2_inflight", inflight, 0);
    tick();
    wb_valid = 1; wb_csr_wen = 1;
    @(negedge clk);
`ifdef SCOREBOARD_CSR_EN
    check("csr3_stall", stall, 1);
`else
    check("csr3_stall", stall, 0);
`endif
    tick();
    wb_valid = 0; wb_csr_wen = 0;
    @(negedge clk);
    check("csr4_stall", stall, 0);
    check("csr4_issue", issue, 1);
    tick();
    idle();
    wb_valid = 1; wb_csr_wen = 1;
    @(negedge clk);
`ifdef SCOREBOARD_CSR_EN
    check("csr5_busy", busy, 1);
`else
    check("csr5_busy", busy, 0);
`endif
    check("csr5_inflight", inflight, 0);
    tick();
    idle();
    @(negedge clk);
    check("csr6_busy", busy, 0);
    tick();

    // Asynchronous reset between edges with four writes pending.
    issue_write(5'd4);
    issue_write(5'd4);
    issue_write(5'd4);
    issue_write(5'd20);
    idle();
    id_valid = 1; id_rs1 = 4; id_rs1_ren = 1; id_rd = 21; id_wen = 1;
    @(negedge clk);
    check("arst_pre_stall", stall, 1);
    check("arst_pre_inflight", inflight, 4);
    #2 rst_n = 0;
    #1;
    check("arst_stall", stall, 0);
    check("arst_inflight", inflight, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err, 0);
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("arst_rel_stall", stall, 0);
    check("arst_rel_issue", issue, 1);
    tick();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scoreboard.md
SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk_i and rst_n_i.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- id_valid_i  in  1  decode holds a valid instruction
- id_rs1_i / id_rs2_i  in  5 each  source register indices
- id_rs1_ren_i / id_rs2_ren_i  in  1 each  source actually read
- id_rd_i  in  5  destination index
- id_wen_i  in  1  instruction writes rd
- id_csr_ren_i / id_csr_wen_i  in  1 each  instruction reads / writes a CSR
- ex_ready_i  in  1  execute stage can accept
- wb_valid_i  in  1  writeback retiring an instruction
- wb_rd_i  in  5  retiring destination
- wb_wen_i  in  1  retiring instruction writes rd
- wb_csr_wen_i  in  1  retiring instruction writes a CSR
- flush_i  in  1  pipeline flush (redirect)
- stall_o  out  1  decode must hold
- issue_o  out  1  instruction leaves decode this cycle
- busy_o  out  1  any write outstanding
- inflight_o  out  3  total outstanding register writes
- err_o  out  1  sticky retire-underflow error

Function
REQ-003 SHALL keep one 2-bit pending counter per register x1..x31; x0 SHALL never be tracked and SHALL never cause a stall.
REQ-004 SHALL assert stall_o = id_valid_i & (RAW | WAW-full | CSR hazard), combinationally from registered state only; there is no same-cycle retire bypass.
REQ-005 RAW: (id_rs1_ren_i & cnt[rs1]!=0) | (id_rs2_ren_i & cnt[rs2]!=0).
REQ-006 WAW-full: id_wen_i & rd!=0 & cnt[rd]==3.
REQ-007 SHALL drive issue_o = id_valid_i & ~stall_o & ex_ready_i & ~flush_i.
REQ-008 On issue_o with id_wen_i & rd!=0, cnt[rd] SHALL increment at the next edge.
REQ-009 On wb_valid_i & wb_wen_i & wb_rd_i!=0, cnt[wb_rd_i] SHALL decrement at the next edge.
REQ-010 Simultaneous increment and decrement of the same register SHALL leave the counter unchanged.
REQ-011 A decrement of a zero counter SHALL leave it 0 and set err_o until reset.
REQ-012 inflight_o SHALL equal the sum of all counters, saturating at 7; busy_o = (inflight_o != 0).
REQ-013 flush_i SHALL clear all counters, including the CSR counter, at the next edge and take priority over same-cycle issue and retire; err_o is unaffected.
REQ-014 Latency: a retire at edge N SHALL allow a dependent issue in the cycle after edge N (one-cycle stall minimum after writeback).

Reset
REQ-015 While rst_n_i is low, all counters, the CSR counter and err_o SHALL be 0. Consequently stall_o = 0 when id_valid_i is low, and busy_o = 0, inflight_o = 0.
REQ-016 Reset asserted mid-operation SHALL discard all pending state immediately, without waiting for a clock edge.

Configuration
REQ-017 Macro SCOREBOARD_CSR_EN. When defined: a 2-bit CSR pending counter exists. It increments on issue_o & id_csr_wen_i and decrements on wb_valid_i & wb_csr_wen_i, using the same rules as REQ-010/011. CSR hazard = (id_csr_ren_i | id_csr_wen_i) & csr_cnt!=0. Its count is included in busy_o but not in inflight_o.
REQ-018 When SCOREBOARD_CSR_EN is undefined: no CSR counter exists, the CSR hazard term is constant 0, and the CSR inputs are ignored.

Verification
REQ-019 Issue addi x5 (wen, rd=5), then add x6,x5,x1 next cycle -> stall_o=1 until the cycle after wb retires rd=5, then issue_o=1.
REQ-020 Issue three writes to x7 with no retire, then a fourth write to x7 -> 4th stalled, inflight_o=3; one retire of x7 -> 4th issues the following cycle.
REQ-021 Instruction reading x0 and writing x0 after an x0 write -> no stall; inflight_o stays 0.
REQ-022 With x3 pending, assert flush_i together with issue and retire -> issue_o=0, next cycle inflight_o=0, busy_o=0; retire x3 again -> err_o=1.
REQ-023 SCOREBOARD_CSR_EN defined: issue csrrw, then csrrs next cycle -> stall_o=1 until one cycle after wb_csr_wen_i; undefined -> no stall.
REQ-024 Drop rst_n_i low asynchronously between edges with 4 pending -> outputs clear immediately; after release, a dependent instruction issues without stall.
